bram_stream_reader: RTL and testbench
=====================================

// Module: bram_stream_reader
// PURPOSE
//  Read-side initiator for the single-port BRAM (addr0/ce0/we0/q0, 1-cycle read latency).
//  On a start pulse it issues len reads from base_addr upward and returns the words, in
//  address order, on a valid/ready stream. A 2-entry output FIFO with credit-based issue
//  absorbs downstream backpressure, so no read word is ever dropped or re-read.
// PARAMETERS
//  DATA_WIDTH  32  BRAM word width and stream data width
//  ADDR_WIDTH  8   BRAM address width; address arithmetic wraps mod 2**ADDR_WIDTH
//  LEN_WIDTH   9   width of len; lengths 0..2**LEN_WIDTH-1 are accepted
// PORTS
//  clk        in   1           single clock; all state changes on rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  start      in   1           1-cycle request; sampled only when busy==0
//  base_addr  in   ADDR_WIDTH  first read address; captured with start
//  len        in   LEN_WIDTH   number of words to read; captured with start
//  busy       out  1           high from the cycle after an accepted start until done
//  done       out  1           1-cycle pulse when the transfer completes
//  addr0      out  ADDR_WIDTH  BRAM address
//  ce0        out  1           BRAM chip enable; one read per cycle with ce0=1
//  we0        out  1           BRAM write enable; constant 0
//  q0         in   DATA_WIDTH  BRAM read data, valid in the cycle after ce0=1
//  m_data     out  DATA_WIDTH  stream data (FIFO head)
//  m_valid    out  1           stream valid (FIFO not empty)
//  m_ready    in   1           stream ready; a word transfers when m_valid & m_ready
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, ce0, we0, m_valid = 0; addr0, m_data = 0.
//    The FIFO, the pending flag and the counters are cleared. Reset mid-transfer discards
//    all words and produces no done pulse.
//  States:
//    IDLE: if start, capture base_addr and len, then go to RUN (len != 0) or to FIN (len == 0).
//    RUN: issue reads per the credit rule. When the last read has been issued, go to DRAIN.
//    DRAIN: no issue. When the last word is accepted on the stream, go to IDLE.
//    FIN: done=1 for one cycle, then go to IDLE.
//  done: pulses in the cycle after the final handshake; busy falls in that same cycle.
//    For len=0, done pulses in the cycle after start, with no ce0.
//  Credit rule: ce0 = (RUN) & (issued < len) & (count + pending - pop <= 1).
//    count = FIFO occupancy (0..2); pending = ce0 was 1 in the previous cycle.
//    pop = m_valid & m_ready.
//  addr0 = base + issued (mod 2**ADDR_WIDTH) while ce0=1; addr0 holds its value otherwise.
//    Reads from 2**ADDR_WIDTH-1 continue at address 0.
//  Capture: when pending=1, q0 is pushed into the FIFO at the end of that cycle.
//    A push and a pop in the same cycle are both honoured, and count is unchanged.
//    The invariant count + pending <= 2 holds, so the FIFO never overflows.
//  Latency: start sampled at edge E0 -> ce0=1 with addr0=base in cycle E0..E1.
//    The first m_valid appears after edge E2; there is no bypass path.
//  Throughput: 1 word/cycle when m_ready is held at 1. While m_ready=0, at most 2 reads
//    are outstanding and ce0 stalls.
//  m_data/m_valid are stable while m_valid=1 and m_ready=0 (AXI-style hold rule).
//  start while busy=1 is ignored; start and the final handshake in the same cycle:
//    the start is ignored.
//  we0 is never asserted; the BRAM contents are never modified.
// TESTING
//  1) Preload mem[1..4]=1..4; start base=1, len=4, m_ready=1.
//     -> ce0 high 4 consecutive cycles, addr0 1,2,3,4.
//     -> m_data 1,2,3,4 on 4 consecutive valid cycles; done pulses once.
//  2) Same as test 1 with m_ready=0 for 6 cycles after the first m_valid.
//     -> at most 2 ce0 cycles issue before the stall; data 1..4 arrive intact and in order.
//  3) Preload mem[254]=A, mem[255]=B, mem[0]=C; start base=254, len=3.
//     -> addr0 254,255,0; stream A,B,C.
//  4) start with len=0 -> no ce0; done in the cycle after start; busy never rises.
//  5) Raise start again mid-transfer -> ignored: the word count equals the original len.
//  6) Drive rst_n=0 after 2 words of a len=8 transfer
//     -> all outputs 0 immediately, no done pulse; a new start then works normally.

Source files
------------

// File: rtl/bram_stream_reader.sv
// Streams len words from a 1-cycle-latency BRAM, starting at base_addr, onto a valid/ready port.
// A 2-entry FIFO plus credit-gated issue absorbs backpressure without dropping or re-reading.
module bram_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic                  ce0,
    output logic                  we0,
    input  logic [DATA_WIDTH-1:0] q0,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  issued_q;
    logic [ADDR_WIDTH-1:0] next_addr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  pending_q;
    logic [DATA_WIDTH-1:0] fifo_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;
    logic                  pop;
    logic [2:0]            credit;
    logic                  accept;

    always_comb begin
        m_valid = (count_q != 2'd0);
        m_data  = fifo_q[rd_ptr_q];
        pop     = m_valid & m_ready;
        // Occupancy the FIFO would reach if nothing new were issued this cycle.
        credit  = {1'b0, count_q} + 3'(pending_q) - 3'(pop);
        ce0     = (state_q == StRun) && (issued_q < len_q) && (credit <= 3'd1);
        addr0   = ce0 ? next_addr_q : addr_q;
        we0     = 1'b0;
        busy    = (state_q == StRun) || (state_q == StDrain);
        done    = (state_q == StFin);
        accept  = (state_q == StIdle) && start;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = (len == '0) ? StFin : StRun;
            end
            StRun: begin
                if (ce0 && (issued_q == len_q - LEN_WIDTH'(1))) state_d = StDrain;
            end
            StDrain: begin
                if (pop && (count_q == 2'd1) && !pending_q) state_d = StFin;
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issued_q    <= '0;
            next_addr_q <= '0;
            addr_q      <= '0;
            pending_q   <= 1'b0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= ce0;
            if (accept) begin
                len_q       <= len;
                issued_q    <= '0;
                next_addr_q <= base_addr;
            end else if (ce0) begin
                issued_q    <= issued_q + LEN_WIDTH'(1);
                next_addr_q <= next_addr_q + ADDR_WIDTH'(1);
                addr_q      <= next_addr_q;
            end
            if (pending_q) begin
                fifo_q[wr_ptr_q] <= q0;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + 2'(pending_q) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model, per-cycle checks against an address-order
// reference of the expected stream, with directed and randomized transfers.
module tb_bram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int LW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic          busy, done, ce0, we0, m_valid, m_ready;
    logic [AW-1:0] addr0;
    logic [DW-1:0] q0, m_data;

    logic [DW-1:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .addr0(addr0), .ce0(ce0), .we0(we0), .q0(q0),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (ce0) q0 <= mem[addr0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_ce0"}, 32'(ce0), 0);
        check({tag, "_we0"}, 32'(we0), 0);
        check({tag, "_valid"}, 32'(m_valid), 0);
        check({tag, "_addr0"}, 32'(addr0), 0);
        check({tag, "_data"}, m_data, 0);
    endtask

    // mode 0: ready held high; 1: ready low in cycles 2..7; 2: random ready.
    task automatic xfer(input logic [7:0] b, input int n, input int mode, input bit restart,
                        input int abort_at);
        int cyc = 0;
        int iss = 0;
        int acc = 0;
        int first_v = -1;
        int budget = 4 * n + 40;
        bit prev_stall = 0;
        logic [31:0] prev_data = 0;
        bit last_hs = (n == 0);
        bit finished = 0;
        @(negedge clk);
        start = 1'b1;
        base_addr = b;
        len = LW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!finished) begin
            if (cyc > budget) begin
                check("timeout_words", 32'(acc), 32'(n));
                break;
            end
            case (mode)
                0: m_ready = 1'b1;
                1: m_ready = !(cyc >= 2 && cyc < 8);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            start = restart && (n >= 2) && (cyc == 3);
            #1;
            check("we0", 32'(we0), 0);
            check("done", 32'(done), 32'(last_hs));
            check("busy", 32'(busy), 32'(n != 0 && !last_hs));
            if (ce0) begin
                check("ce0_within_len", 32'(iss < n), 1);
                check("addr0", 32'(addr0), (int'(b) + iss) % 256);
                iss++;
            end
            if (mode == 0 && !last_hs) begin
                check("ce0_stream", 32'(ce0), 32'(cyc < n));
                check("valid_stream", 32'(m_valid), 32'(cyc >= 2 && cyc < n + 2));
            end
            if (last_hs) begin
                finished = 1;
            end else begin
                if (m_valid && first_v < 0) begin
                    first_v = cyc;
                    check("first_valid_cycle", 32'(cyc), 2);
                end
                if (prev_stall) begin
                    check("hold_valid", 32'(m_valid), 1);
                    check("hold_data", m_data, prev_data);
                end
                prev_stall = m_valid && !m_ready;
                prev_data = m_data;
                if (m_valid && m_ready) begin
                    check("data", m_data, mem[(int'(b) + acc) % 256]);
                    acc++;
                    last_hs = (acc == n);
                end
                check("outstanding", 32'((iss - acc) <= 2), 1);
                @(posedge clk);
                #1;
                cyc++;
                if (abort_at >= 0 && acc >= abort_at) begin
                    rst_n = 1'b0;
                    start = 1'b0;
                    #1;
                    check_zero_outputs("abort");
                    @(posedge clk);
                    #1;
                    check("abort_no_done", 32'(done), 0);
                    rst_n = 1'b1;
                    return;
                end
            end
        end
        start = 1'b0;
        check("word_count", 32'(acc), 32'(n));
        m_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("idle_ce0", 32'(ce0), 0);
            check("idle_valid", 32'(m_valid), 0);
            check("idle_busy", 32'(busy), 0);
            check("idle_done", 32'(done), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        for (int i = 1; i <= 4; i++) mem[i] = 32'(i);
        mem[254] = 32'h0000_00aa;
        mem[255] = 32'h0000_00bb;
        mem[0]   = 32'h0000_00cc;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        m_ready = 1'b0;
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        xfer(8'd1, 4, 0, 1'b0, -1);
        xfer(8'd1, 4, 1, 1'b0, -1);
        xfer(8'd254, 3, 0, 1'b0, -1);
        xfer(8'd7, 0, 0, 1'b0, -1);
        xfer(8'd10, 8, 2, 1'b1, -1);
        xfer(8'd20, 8, 0, 1'b0, 2);
        xfer(8'd1, 4, 0, 1'b0, -1);
        for (int t = 0; t < 12; t++) begin
            xfer(8'($urandom), int'($urandom_range(1, 24)), 2, 1'($urandom_range(0, 1)), -1);
        end
        xfer(8'd200, 300, 0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
